// File: rtl/sev_seg_scan_ctrl_if.sv
// Bus bundle for the seven-segment scan controller: shadow-buffer write port,
// swap handshake, frame marker and the registered display drive lines.
interface sev_seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_tick;
  logic [7:0] out_dis;
  logic [6:0] out_seg;
  logic       out_dp;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, wr_blank, swap_req,
    input  swap_ack, frame_tick, out_dis, out_seg, out_dp
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, wr_blank, swap_req,
    output swap_ack, frame_tick, out_dis, out_seg, out_dp
  );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered digit
// contents. Each digit slot is a BLANK guard phase followed by an ON phase;
// the shadow buffer is copied to the active buffer only at a frame boundary.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_CYC cycles ahead of digit idx
//   ST_ON    | digit idx lit for ON_CYC cycles (dark if its blank flag set)
module sev_seg_scan_ctrl #(
  parameter int ON_CYC    = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  sev_seg_scan_ctrl_if.slave    bus
);

  localparam int MAXC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Entry layout: {blank, dp, data[3:0]}; reset value is a dark digit.
  localparam logic [5:0] ENTRY_RST = 6'b100000;

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pending, pending_n;
  logic          boundary, do_swap;
  logic [5:0]    shadow [8];
  logic [5:0]    active [8];
  logic [5:0]    ent_n;
  logic [7:0]    dis_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next-state, swap decision and next output values. Outputs are derived from
  // the next state so the registered drive lines track the FSM without lag.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt + CW'(1);
    boundary = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_n = ST_ON;
          cnt_n   = '0;
        end
      end
      ST_ON: begin
        if (cnt == CW'(ON_CYC - 1)) begin
          state_n  = ST_BLANK;
          cnt_n    = '0;
          idx_n    = idx + 3'd1;
          boundary = (idx == 3'd7);
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase

    do_swap   = boundary & (pending | bus.swap_req);
    pending_n = boundary ? 1'b0 : (pending | bus.swap_req);

    // A swap only lands when heading into BLANK, so the current active entry
    // is always the right source for an ON slot.
    ent_n = active[idx_n];
    dis_n = 8'hFF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (state_n == ST_ON && !ent_n[5]) begin
      dis_n = ~(8'h80 >> idx_n);
      seg_n = hex7(ent_n[3:0]);
      dp_n  = ~ent_n[4];
    end
  end

  // State, buffers, swap bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BLANK;
      idx            <= '0;
      cnt            <= '0;
      pending        <= 1'b0;
      bus.swap_ack   <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.out_dis    <= 8'hFF;
      bus.out_seg    <= 7'h7F;
      bus.out_dp     <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= ENTRY_RST;
        active[i] <= ENTRY_RST;
      end
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      cnt            <= cnt_n;
      pending        <= pending_n;
      bus.swap_ack   <= do_swap;
      bus.frame_tick <= boundary;
      bus.out_dis    <= dis_n;
      bus.out_seg    <= seg_n;
      bus.out_dp     <= dp_n;
      // Copy reads the pre-edge shadow, so a same-cycle write is not included.
      if (do_swap) begin
        for (int i = 0; i < 8; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (bus.wr_en) begin
        shadow[bus.wr_addr] <= {bus.wr_blank, bus.wr_dp, bus.wr_data};
      end
    end
  end

endmodule
